// File: rtl/wbu_writeback.sv
// Write-back unit: formats load data, drives the register-file write port,
// pulses commit with the retired PC and counts retired instructions.
module wbu_writeback #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [1:0]            in_sel,
    input  logic [DATA_WIDTH-1:0] in_alu,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [2:0]            in_ld_fmt,
    input  logic [1:0]            in_ld_off,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rready,
    output logic                  rf_valid,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic [63:0]           instret
);

    localparam int unsigned HALF_WIDTH = 16;
    localparam int unsigned BYTE_WIDTH = 8;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] FMT_LB  = 3'b000;
    localparam logic [2:0] FMT_LH  = 3'b001;
    localparam logic [2:0] FMT_LBU = 3'b100;
    localparam logic [2:0] FMT_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  lat_rd;
    logic                   lat_wen;
    logic [DATA_WIDTH-1:0]  lat_pc;
    logic [2:0]             lat_fmt;
    logic [1:0]             lat_off;

    logic                   hs_c;
    logic [DATA_WIDTH-1:0]  ex_data_c;
    logic [DATA_WIDTH-1:0]  ld_data_c;
    logic [DATA_WIDTH-1:0]  ld_shift_c;
    logic [HALF_WIDTH-1:0]  ld_half_c;

    assign in_ready = rst_n && (state != WAIT_MEM);
    assign hs_c     = in_valid && in_ready;

    // Non-load result: link writes pc+4, every other non-load code takes the ALU value
    assign ex_data_c = (in_sel == SEL_LINK) ? (in_pc + DATA_WIDTH'(4)) : in_alu;

    // Load data formatting from the latched funct3 and byte offset
    always_comb begin
        ld_shift_c = mem_rdata >> {lat_off, 3'b000};
        ld_half_c  = mem_rdata[{lat_off[1], 4'b0000} +: HALF_WIDTH];
        ld_data_c  = mem_rdata;
        case (lat_fmt)
            FMT_LB:  ld_data_c = {{(DATA_WIDTH-BYTE_WIDTH){ld_shift_c[BYTE_WIDTH-1]}},
                                  ld_shift_c[BYTE_WIDTH-1:0]};
            FMT_LBU: ld_data_c = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, ld_shift_c[BYTE_WIDTH-1:0]};
            FMT_LH:  ld_data_c = {{(DATA_WIDTH-HALF_WIDTH){ld_half_c[HALF_WIDTH-1]}}, ld_half_c};
            FMT_LHU: ld_data_c = {{(DATA_WIDTH-HALF_WIDTH){1'b0}}, ld_half_c};
            default: ld_data_c = mem_rdata;
        endcase
    end

    // FSM with registered write-port, commit and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_rd     <= '0;
            lat_wen    <= 1'b0;
            lat_pc     <= '0;
            lat_fmt    <= '0;
            lat_off    <= '0;
            mem_rready <= 1'b0;
            rf_valid   <= 1'b0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            commit     <= 1'b0;
            commit_pc  <= '0;
            instret    <= '0;
        end else begin
            rf_valid   <= 1'b0;
            rf_wen     <= 1'b0;
            commit     <= 1'b0;
            mem_rready <= 1'b0;
            if (state == WRITE) begin
                instret <= instret + 64'd1;
            end
            unique case (state)
                IDLE, WRITE: begin
                    if (hs_c) begin
                        lat_rd  <= in_rd;
                        lat_wen <= in_wen;
                        lat_pc  <= in_pc;
                        lat_fmt <= in_ld_fmt;
                        lat_off <= in_ld_off;
                        if (in_sel == SEL_LOAD) begin
                            state      <= WAIT_MEM;
                            mem_rready <= 1'b1;
                        end else begin
                            state     <= WRITE;
                            rf_valid  <= 1'b1;
                            commit    <= 1'b1;
                            rf_wen    <= in_wen && (in_rd != '0);
                            rf_waddr  <= in_rd;
                            rf_wdata  <= ex_data_c;
                            commit_pc <= in_pc;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state     <= WRITE;
                        rf_valid  <= 1'b1;
                        commit    <= 1'b1;
                        rf_wen    <= lat_wen && (lat_rd != '0);
                        rf_waddr  <= lat_rd;
                        rf_wdata  <= ld_data_c;
                        commit_pc <= lat_pc;
                    end else begin
                        mem_rready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbu_writeback.sv
// Directed bench for wbu_writeback: outcome-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_wbu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [1:0]  in_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [2:0]  in_ld_fmt;
    logic [1:0]  in_ld_off;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;
    logic        rf_valid;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit;
    logic [31:0] commit_pc;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    wbu_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .in_sel     (in_sel),
        .in_alu     (in_alu),
        .in_pc      (in_pc),
        .in_ld_fmt  (in_ld_fmt),
        .in_ld_off  (in_ld_off),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rready (mem_rready),
        .rf_valid   (rf_valid),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .commit     (commit),
        .commit_pc  (commit_pc),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result computed byte-wise from the RISC-V load rules
    function automatic logic [31:0] fmt_load(input logic [2:0] f, input logic [1:0] o,
                                             input logic [31:0] w);
        logic [7:0]  by [4];
        logic [7:0]  b;
        logic [15:0] h;
        by[0] = w[7:0];   by[1] = w[15:8];
        by[2] = w[23:16]; by[3] = w[31:24];
        b = by[o];
        h = o[1] ? {by[3], by[2]} : {by[1], by[0]};
        case (f)
            3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h000000, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0000, h};
            3'b101:  return {16'h0000, h};
            default: return w;
        endcase
    endfunction

    // Model: what write (if any) is presented in the cycle after each edge
    bit          m_started = 0;
    bit          m_reset   = 0;
    bit          m_pend    = 0;
    bit          m_wr      = 0;
    bit          m_wen     = 0;
    logic [4:0]  m_waddr   = '0;
    logic [31:0] m_wdata   = '0;
    logic [31:0] m_pc      = '0;
    logic [63:0] m_instret = '0;
    logic [4:0]  p_rd;
    bit          p_wen;
    logic [31:0] p_pc;
    logic [2:0]  p_fmt;
    logic [1:0]  p_off;

    always @(posedge clk) begin
        m_started = 1;
        if (!rst_n) begin
            m_reset = 1; m_pend = 0; m_wr = 0; m_instret = '0;
        end else begin
            m_reset = 0;
            if (m_wr) m_instret = m_instret + 1;
            m_wr = 0;
            if (m_pend) begin
                if (mem_rvalid) begin
                    m_wr = 1; m_wen = p_wen && (p_rd != 0); m_waddr = p_rd;
                    m_wdata = fmt_load(p_fmt, p_off, mem_rdata); m_pc = p_pc;
                    m_pend = 0;
                end
            end else if (in_valid) begin
                if (in_sel == 2'b01) begin
                    m_pend = 1; p_rd = in_rd; p_wen = in_wen; p_pc = in_pc;
                    p_fmt = in_ld_fmt; p_off = in_ld_off;
                end else begin
                    m_wr = 1; m_wen = in_wen && (in_rd != 0); m_waddr = in_rd; m_pc = in_pc;
                    m_wdata = (in_sel == 2'b10) ? in_pc + 32'd4 : in_alu;
                end
            end
        end
    end

    // Cycle compare against the model, just after each edge
    always @(posedge clk) begin
        #1;
        if (m_started) begin
            chk("rf_valid", rf_valid, m_wr);
            chk("commit", commit, m_wr);
            chk("mem_rready", mem_rready, m_pend);
            chk("in_ready", in_ready, rst_n && !m_pend);
            chk("instret", instret, m_instret);
            if (m_wr) begin
                chk("rf_wen", rf_wen, m_wen);
                chk("rf_waddr", rf_waddr, m_waddr);
                chk("rf_wdata", rf_wdata, m_wdata);
                chk("commit_pc", commit_pc, m_pc);
            end
            if (m_reset) begin
                chk("rst_wen", rf_wen, 0);
                chk("rst_waddr", rf_waddr, 0);
                chk("rst_wdata", rf_wdata, 0);
                chk("rst_commit_pc", commit_pc, 0);
            end
        end
    end

    // One-cycle handshake; returns at the negedge after the accepting edge
    task automatic issue(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] fmt, input logic [1:0] off);
        @(negedge clk);
        in_valid = 1; in_rd = rd; in_wen = wen; in_sel = sel;
        in_alu = alu; in_pc = pc; in_ld_fmt = fmt; in_ld_off = off;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic do_load(input logic [2:0] fmt, input logic [1:0] off, input int delay,
                           input logic [31:0] word, input logic [31:0] exp, input string name);
        issue(5'd9, 1'b1, 2'b01, 32'h0, 32'h00000200, fmt, off);
        for (int i = 0; i < delay; i++) begin
            chk({name, "_wait_ready"}, in_ready, 0);
            chk({name, "_wait_valid"}, rf_valid, 0);
            @(negedge clk);
        end
        mem_rvalid = 1; mem_rdata = word;
        @(negedge clk);
        mem_rvalid = 0;
        chk({name, "_valid"}, rf_valid, 1);
        chk({name, "_data"}, rf_wdata, exp);
    endtask

    logic [63:0] start_cnt;

    initial begin
        rst_n = 0; in_valid = 0; in_rd = '0; in_wen = 0; in_sel = '0; in_alu = '0;
        in_pc = '0; in_ld_fmt = '0; in_ld_off = '0; mem_rvalid = 0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_instret", instret, 0);
        chk("reset_rf_valid", rf_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        rst_n = 1;

        // ALU op
        issue(5'd5, 1'b1, 2'b00, 32'hDEADBEEF, 32'h00000100, 3'b000, 2'b00);
        chk("alu_valid", rf_valid, 1);
        chk("alu_wen", rf_wen, 1);
        chk("alu_waddr", rf_waddr, 5);
        chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
        chk("alu_commit", commit, 1);
        @(negedge clk);
        chk("alu_instret", instret, 1);

        // Link ops, rd=1 then rd=0
        issue(5'd1, 1'b1, 2'b10, 32'h0, 32'h80000010, 3'b000, 2'b00);
        chk("link_wdata", rf_wdata, 32'h80000014);
        chk("link_commit_pc", commit_pc, 32'h80000010);
        issue(5'd0, 1'b1, 2'b10, 32'h0, 32'h80000010, 3'b000, 2'b00);
        chk("link_x0_valid", rf_valid, 1);
        chk("link_x0_wen", rf_wen, 0);
        chk("link_x0_commit", commit, 1);

        // Load formatting
        do_load(3'b000, 2'd0, 1, 32'h8081F0F7, 32'hFFFFFFF7, "lb0");
        do_load(3'b100, 2'd3, 1, 32'h8081F0F7, 32'h00000080, "lbu3");
        do_load(3'b001, 2'd2, 1, 32'h8081F0F7, 32'hFFFF8081, "lh2");
        do_load(3'b101, 2'd0, 1, 32'h8081F0F7, 32'h0000F0F7, "lhu0");
        do_load(3'b010, 2'd1, 1, 32'h8081F0F7, 32'h8081F0F7, "lw");
        do_load(3'b111, 2'd2, 0, 32'h12345678, 32'h12345678, "undef");

        // Delayed memory response
        do_load(3'b001, 2'd1, 4, 32'h00017FFF, 32'h00007FFF, "lh_slow");

        // Stray mem_rvalid while idle
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 0;
        chk("idle_rvalid_valid", rf_valid, 0);
        chk("idle_rvalid_rready", mem_rready, 0);

        // Back-to-back ALU ops
        @(negedge clk);
        start_cnt = m_instret;
        in_valid = 1; in_sel = 2'b00; in_wen = 1; in_rd = 5'd10; in_alu = 32'h0000000A; in_pc = 32'h300;
        @(negedge clk);
        chk("b2b_a", rf_wdata, 32'h0000000A);
        in_rd = 5'd11; in_alu = 32'h0000000B; in_pc = 32'h304;
        @(negedge clk);
        chk("b2b_b", rf_wdata, 32'h0000000B);
        chk("b2b_b_valid", rf_valid, 1);
        in_rd = 5'd12; in_alu = 32'h0000000C; in_pc = 32'h308;
        @(negedge clk);
        in_valid = 0;
        chk("b2b_c", rf_wdata, 32'h0000000C);
        chk("b2b_c_addr", rf_waddr, 12);
        @(negedge clk);
        chk("b2b_idle", rf_valid, 0);
        chk("b2b_instret", instret, start_cnt + 3);

        // Reset while waiting for memory
        issue(5'd7, 1'b1, 2'b01, 32'h0, 32'h400, 3'b010, 2'b00);
        @(negedge clk);
        rst_n = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
        @(negedge clk);
        rst_n = 1; mem_rvalid = 0;
        chk("rstw_valid", rf_valid, 0);
        chk("rstw_commit", commit, 0);
        chk("rstw_instret", instret, 0);
        chk("rstw_rready", mem_rready, 0);
        chk("rstw_wdata", rf_wdata, 0);
        @(negedge clk);
        chk("rstw_after_valid", rf_valid, 0);
        issue(5'd3, 1'b1, 2'b00, 32'h12345678, 32'h500, 3'b000, 2'b00);
        chk("post_rst_wdata", rf_wdata, 32'h12345678);
        chk("post_rst_waddr", rf_waddr, 3);
        @(negedge clk);
        chk("post_rst_instret", instret, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
